ram_1w1r_bist: RTL and testbench

- Built-in self-test initiator that drives the write and read ports of a ram_1w1r_sync instance, which has one write port and one synchronous read port.
- Runs a 4-phase march over every address and compares each read word against the expected pattern.
- Stops on the first mismatch and reports its address, the data read and the data expected.
- Sits beside the RAM; when enabled, its outputs connect straight to the RAM ports through the integration mux.

---
 rtl/ram_1w1r_bist_if.sv | 29 ++
 rtl/ram_1w1r_bist.sv | 170 +++++++++++++++++
 tb/tb_ram_1w1r_bist.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ram_1w1r_bist_if.sv
// RAM-side bus between the BIST initiator and a ram_1w1r_sync instance.
// master: BIST side. It drives the write port and the read request, and receives the read data.
// slave : RAM side.
//   wr_valid/wr_addr/wr_data : write port
//   rd_valid/rd_addr         : read request
//   rd_data                  : read data, valid the cycle after rd_valid is sampled high
interface ram_1w1r_bist_if #(
    parameter int unsigned width_p = 8,
    parameter int unsigned depth_p = 512
);
    localparam int unsigned addr_width_lp = $clog2(depth_p);

    logic                     wr_valid;
    logic [addr_width_lp-1:0] wr_addr;
    logic [width_p-1:0]       wr_data;
    logic                     rd_valid;
    logic [addr_width_lp-1:0] rd_addr;
    logic [width_p-1:0]       rd_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        output rd_data
    );
endinterface

// File: rtl/ram_1w1r_bist.sv
// March BIST initiator for a 1-write / 1-sync-read RAM.
// The march runs in four phases:
//   W0 writes pattern_p in ascending order.
//   R0 reads back in ascending order.
//   W1 writes ~pattern_p in descending order.
//   R1 reads back in descending order.
// The run stops at the first mismatch.
// Ports:
//   clk_i, reset_i (async, active-low)
//   start_i         : start pulse, honoured only when idle
//   busy_o          : run in progress
//   done_o/pass_o/fail_o : sticky result flags
//   fail_addr_o/fail_data_o/fail_expected_o : first-mismatch record
//   ram             : RAM-side bus (master modport)
module ram_1w1r_bist #(
    parameter int unsigned         width_p   = 8,
    parameter int unsigned         depth_p   = 512,
    parameter logic [width_p-1:0]  pattern_p = width_p'({((width_p + 1) / 2){2'b01}})
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic                       fail_o,
    output logic [$clog2(depth_p)-1:0] fail_addr_o,
    output logic [width_p-1:0]         fail_data_o,
    output logic [width_p-1:0]         fail_expected_o,
    ram_1w1r_bist_if.master            ram
);
    localparam int unsigned              addr_width_lp = $clog2(depth_p);
    localparam logic [addr_width_lp-1:0] last_addr_lp  = addr_width_lp'(depth_p - 1);

    typedef enum logic [2:0] {StIdle, StW0, StR0, StW1, StR1, StDrain} state_e;

    state_e                   state_q, state_d;
    logic [addr_width_lp-1:0] addr_q, addr_d;
    logic                     done_q, done_d, pass_q, pass_d, fail_q, fail_d;
    logic [addr_width_lp-1:0] fail_addr_q, fail_addr_d;
    logic [width_p-1:0]       fail_data_q, fail_data_d, fail_exp_q, fail_exp_d;
    // Compare pipeline: one entry per issued read, checked the following cycle.
    logic                     cmp_valid_q, cmp_valid_d;
    logic [addr_width_lp-1:0] cmp_addr_q, cmp_addr_d;
    logic [width_p-1:0]       cmp_exp_q, cmp_exp_d;

    logic wr_en, rd_en, mismatch;

    assign wr_en    = (state_q == StW0) || (state_q == StW1);
    assign rd_en    = (state_q == StR0) || (state_q == StR1);
    assign mismatch = cmp_valid_q && (ram.rd_data != cmp_exp_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        fail_exp_d  = fail_exp_q;
        cmp_valid_d = rd_en;
        cmp_addr_d  = addr_q;
        cmp_exp_d   = (state_q == StR1) ? ~pattern_p : pattern_p;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StW0;
                    addr_d      = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    fail_exp_d  = '0;
                end
            end
            StW0: begin
                if (addr_q == last_addr_lp) begin
                    state_d = StR0;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StR0: begin
                // Counter holds at the top: W1 starts where R0 ended.
                if (addr_q == last_addr_lp) state_d = StW1;
                else                        addr_d  = addr_q + 1'b1;
            end
            StW1: begin
                if (addr_q == '0) begin
                    state_d = StR1;
                    addr_d  = last_addr_lp;
                end else begin
                    addr_d = addr_q - 1'b1;
                end
            end
            StR1: begin
                if (addr_q == '0) state_d = StDrain;
                else              addr_d  = addr_q - 1'b1;
            end
            StDrain: begin
                state_d = StIdle;
                done_d  = 1'b1;
                pass_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // A failed compare overrides whatever the phase logic chose.
        if (mismatch) begin
            state_d     = StIdle;
            done_d      = 1'b1;
            pass_d      = 1'b0;
            fail_d      = 1'b1;
            fail_addr_d = cmp_addr_q;
            fail_data_d = ram.rd_data;
            fail_exp_d  = cmp_exp_q;
            cmp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_exp_q  <= '0;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_exp_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_exp_q  <= fail_exp_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_exp_q   <= cmp_exp_d;
        end
    end

    // RAM-side outputs are decoded from state, so they are zero whenever not in a phase.
    always_comb begin
        ram.wr_valid = wr_en;
        ram.wr_addr  = wr_en ? addr_q : '0;
        ram.wr_data  = (state_q == StW0) ? pattern_p :
                       (state_q == StW1) ? ~pattern_p : '0;
        ram.rd_valid = rd_en;
        ram.rd_addr  = rd_en ? addr_q : '0;
    end

    assign busy_o          = (state_q != StIdle);
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign fail_o          = fail_q;
    assign fail_addr_o     = fail_addr_q;
    assign fail_data_o     = fail_data_q;
    assign fail_expected_o = fail_exp_q;
endmodule

// File: tb/tb_ram_1w1r_bist.sv
// Bench for ram_1w1r_bist (width 8, depth 16) with a behavioural RAM that can hold one
// stuck-at bit fault. The expected op trace and outcome of each run come from an abstract
// march model.
module tb_ram_1w1r_bist;
    localparam int unsigned W = 8;
    localparam int unsigned D = 16;

    typedef struct packed {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
    } op_t;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       start_i = 1'b0;
    logic       busy_o, done_o, pass_o, fail_o;
    logic [3:0] fail_addr_o;
    logic [7:0] fail_data_o, fail_expected_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Fault configuration of the behavioural RAM.
    bit         f_en   = 1'b0;
    logic [3:0] f_addr = '0;
    logic [7:0] f_mask = '0;
    bit         f_val  = 1'b0;

    ram_1w1r_bist_if #(.width_p(W), .depth_p(D)) ram_if ();

    ram_1w1r_bist #(.width_p(W), .depth_p(D)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .start_i         (start_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .pass_o          (pass_o),
        .fail_o          (fail_o),
        .fail_addr_o     (fail_addr_o),
        .fail_data_o     (fail_data_o),
        .fail_expected_o (fail_expected_o),
        .ram             (ram_if)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] faulty(input logic [3:0] a, input logic [7:0] d);
        if (f_en && a == f_addr) return f_val ? (d | f_mask) : (d & ~f_mask);
        return d;
    endfunction

    logic [7:0] mem [D];
    always_ff @(posedge clk_i) begin
        if (ram_if.wr_valid) mem[ram_if.wr_addr] <= faulty(ram_if.wr_addr, ram_if.wr_data);
        if (ram_if.rd_valid) ram_if.rd_data <= mem[ram_if.rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One start pulse, then monitor until busy drops, and compare against the march model.
    task automatic run_march(input string tag, input bit extra_start);
        op_t        full[$];
        op_t        got[$];
        logic [7:0] m [D];
        int         fidx, n, nops, exp_busy;
        logic [7:0] e_data, e_exp;
        logic [3:0] e_addr;

        for (int a = 0; a < 16; a++) full.push_back('{1'b1, 4'(a), 8'h55});
        for (int a = 0; a < 16; a++) full.push_back('{1'b0, 4'(a), 8'h00});
        for (int a = 15; a >= 0; a--) full.push_back('{1'b1, 4'(a), 8'hAA});
        for (int a = 15; a >= 0; a--) full.push_back('{1'b0, 4'(a), 8'h00});

        fidx = -1;
        e_addr = '0; e_data = '0; e_exp = '0;
        for (int i = 0; i < 64; i++) begin
            if (full[i].wr) begin
                m[full[i].addr] = faulty(full[i].addr, full[i].data);
            end else if (m[full[i].addr] != ((i < 32) ? 8'h55 : 8'hAA)) begin
                fidx   = i;
                e_addr = full[i].addr;
                e_data = m[full[i].addr];
                e_exp  = (i < 32) ? 8'h55 : 8'hAA;
                break;
            end
        end
        // The op following the failing read is still issued during the compare cycle.
        exp_busy = (fidx < 0) ? 4 * D + 1 : fidx + 2;
        nops     = (fidx < 0) ? 64 : ((fidx + 2 > 64) ? 64 : fidx + 2);

        @(negedge clk_i) start_i = 1'b1;
        @(negedge clk_i) start_i = 1'b0;
        check({tag, ":start_busy"}, 32'(busy_o), 32'd1);
        check({tag, ":start_clear"}, {done_o, pass_o, fail_o, fail_addr_o, fail_data_o,
              fail_expected_o}, 32'd0);

        n = 0;
        while (busy_o && n < 200) begin
            check({tag, ":excl"}, 32'(ram_if.wr_valid & ram_if.rd_valid), 32'd0);
            if (ram_if.wr_valid) got.push_back('{1'b1, ram_if.wr_addr, ram_if.wr_data});
            else if (ram_if.rd_valid) got.push_back('{1'b0, ram_if.rd_addr, 8'h00});
            n++;
            start_i = extra_start && (n == 30 || n == 50);
            @(negedge clk_i);
        end
        start_i = 1'b0;

        check({tag, ":busy_cycles"}, 32'(n), 32'(exp_busy));
        check({tag, ":done"}, 32'(done_o), 32'd1);
        check({tag, ":pass"}, 32'(pass_o), 32'(fidx < 0));
        check({tag, ":fail"}, 32'(fail_o), 32'(fidx >= 0));
        check({tag, ":fail_addr"}, 32'(fail_addr_o), 32'(e_addr));
        check({tag, ":fail_data"}, 32'(fail_data_o), 32'(e_data));
        check({tag, ":fail_expected"}, 32'(fail_expected_o), 32'(e_exp));
        check({tag, ":nops"}, 32'(got.size()), 32'(nops));
        for (int i = 0; i < nops && i < got.size(); i++)
            check({tag, ":op"}, 32'(got[i]), 32'(full[i]));
        // No activity once idle.
        check({tag, ":idle_bus"}, 32'(ram_if.wr_valid | ram_if.rd_valid), 32'd0);
    endtask

    task automatic set_fault(input bit en, input int a, input int b, input bit v);
        f_en   = en;
        f_addr = 4'(a);
        f_mask = 8'(1 << b);
        f_val  = v;
    endtask

    initial begin
        #12;
        check("rst_flags", {busy_o, done_o, pass_o, fail_o}, 32'd0);
        check("rst_fail_bus", {fail_addr_o, fail_data_o, fail_expected_o}, 32'd0);
        check("rst_ram_bus", {ram_if.wr_valid, ram_if.wr_addr, ram_if.wr_data,
              ram_if.rd_valid, ram_if.rd_addr}, 32'd0);
        @(negedge clk_i) reset_i = 1'b1;

        set_fault(1'b0, 0, 0, 1'b0);
        run_march("pass", 1'b0);
        set_fault(1'b1, 3, 0, 1'b0);
        run_march("sa0_a3", 1'b0);
        set_fault(1'b0, 0, 0, 1'b0);
        run_march("rerun", 1'b0);
        set_fault(1'b1, 5, 0, 1'b1);
        run_march("sa1_a5", 1'b0);
        set_fault(1'b0, 0, 0, 1'b0);
        run_march("restart_ignored", 1'b1);

        // Reset in the middle of R0.
        @(negedge clk_i) start_i = 1'b1;
        @(negedge clk_i) start_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check("pre_reset_rd", 32'(ram_if.rd_valid), 32'd1);
        #2 reset_i = 1'b0;
        #1;
        check("mid_rst_flags", {busy_o, done_o, pass_o, fail_o}, 32'd0);
        check("mid_rst_bus", {ram_if.wr_valid, ram_if.rd_valid, ram_if.rd_addr,
              ram_if.wr_addr, fail_addr_o}, 32'd0);
        @(negedge clk_i) reset_i = 1'b1;
        run_march("after_reset", 1'b0);

        for (int k = 0; k < 6; k++) begin
            set_fault(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            run_march($sformatf("rand%0d", k), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
